uart_tx: RTL and testbench
==========================

# uart_tx

Serial UART transmitter that consumes bytes from the string-transmit stage and shifts them onto the serial line. It accepts one byte per `tx_ready` rising edge. It then drives a start bit, 8 data bits LSB first, an optional parity bit and 1 or 2 stop bits, and reports completion on the level signal `tx_done`. It sits between the string/byte sources and the board TX pin.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per bit period (50 MHz / 115200). Must be ≥ 2.
- `PARITY`, default 0: parity mode. 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.
- `clock`  in  1: system clock. All logic is on the rising edge.
- `reset`  in  1: asynchronous, active-low.
- `tx_data`  in  8: byte to send. Sampled only on accept.
- `tx_ready`  in  1: request. A rising edge requests transmission of `tx_data`.
- `tx_done`  out  1: level signal. 1 = idle / previous frame complete, 0 = frame in progress.
- `tx`  out  1: serial line. Idles high.

## Operation
- Reset values: `tx`=1, `tx_done`=1, state IDLE, `tx_ready_last`=0, bit counter=0, baud counter=0.
- Edge detect: `tx_ready_last` is a register copy of `tx_ready`. `edge = tx_ready && !tx_ready_last`.
- States (one-hot): IDLE, START, DATA, PARITY, STOP.
  - IDLE: if `edge`, latch `tx_data` into the shift register, compute parity, set `tx`<=0 and `tx_done`<=0, go to START.
  - START: after `CLKS_PER_BIT` cycles, drive bit 0 and go to DATA.
  - DATA: shift each bit out for `CLKS_PER_BIT` cycles, LSB first. After bit 7, go to PARITY if `PARITY`≠0, else go to STOP with `tx`<=1.
  - PARITY: drive the parity bit for one bit period, then go to STOP with `tx`<=1.
    - Even: bit = XOR of the data bits.
    - Odd: bit = inverse of that XOR.
  - STOP: hold `tx`=1 for `STOP_BITS`×`CLKS_PER_BIT` cycles, then set `tx_done`<=1 and go to IDLE.
- A rising edge of `tx_ready` outside IDLE is ignored, not queued. `tx_ready_last` still tracks the input.
- `tx_ready` held high across frame completion does not start a second frame. It must be seen low for at least one clock and then high again. This is the re-arm rule the string stage relies on: it drops `tx_ready` in response to `tx_done` and then reasserts it.
- Changes to `tx_data` after accept have no effect on the frame in flight.
- Illegal or unreached state encodings return to IDLE with `tx`=1 and `tx_done`=1.
- Baud counter width is `$clog2(CLKS_PER_BIT)`. It counts 0..`CLKS_PER_BIT`-1, then wraps and advances the bit.

## Timing
- Accept latency: an edge seen in cycle A gives `tx`=0 and `tx_done`=0 from cycle A+1.
- Frame length is F = `CLKS_PER_BIT`×(1+8+P+`STOP_BITS`), where P = 1 if parity is enabled, else 0.
- `tx_done` is low for exactly F cycles, A+1 through A+F, and rises in cycle A+F+1.
- Fastest re-arm: `tx_ready` low in one cycle and high in the next. A new frame can start 1 cycle after `tx_done` is seen high and `tx_ready` is seen low-then-high.
- Reset asserted mid-frame: `tx` goes to 1 and `tx_done` to 1 immediately. The frame is abandoned.
- `tx_ready` high at reset release: `tx_ready_last`=0, so the first clock detects an edge and a frame starts.

## Structure
- Shared package `uart_pkg` holds:
  - state encoding constants (`UART_TX_IDLE`/`START`/`DATA`/`PARITY`/`STOP`, one-hot 5-bit);
  - parity mode constants `PARITY_NONE`/`EVEN`/`ODD`;
  - the default `CLKS_PER_BIT`.
- One sub-module: `uart_baud_gen`. It is a restartable counter producing a one-cycle `bit_tick` every `CLKS_PER_BIT` cycles, with synchronous `clear` on accept. The same sub-module is reused by the future `uart_rx`.

## Test plan
Test benches use `CLKS_PER_BIT`=4.
- 0x55, no parity, 1 stop -> `tx` = 0,1,0,1,0,1,0,1,0,1, each held 4 cycles. `tx_done` is low for exactly 40 cycles, then high.
- `PARITY`=1 with 0x03 -> parity bit 0. `PARITY`=2 with 0x03 -> parity bit 1. `PARITY`=1 with 0x07 -> parity bit 1. Frame is 44 cycles; with `STOP_BITS`=2 it is 48 cycles.
- `tx_ready` held high through the end of a 0x41 frame -> no second start bit. Pulse `tx_ready` low 1 cycle then high -> the next frame's start bit appears 1 cycle after the rising edge.
- Back-to-back with the string handshake model sending "Hi\0" -> the line carries 0x48 then 0x69 with no corrupted bits, and exactly two frames.
- `tx_ready` re-edge mid-frame, plus `tx_data` changed from 0xA5 to 0xFF mid-frame -> one frame only, and it carries 0xA5.
- Reset asserted during the DATA state -> `tx`=1 and `tx_done`=1 in the same cycle. With `tx_ready`=1 at release, a fresh frame starts on the first clock.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity modes and default bit timing.
package uart_pkg;

  typedef enum logic [4:0] {
    UART_TX_IDLE   = 5'b00001,
    UART_TX_START  = 5'b00010,
    UART_TX_DATA   = 5'b00100,
    UART_TX_PARITY = 5'b01000,
    UART_TX_STOP   = 5'b10000
  } uart_tx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // 50 MHz system clock at 115200 baud
  localparam int UART_CLKS_PER_BIT = 434;

  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    return (mode == PARITY_ODD) ? ~(^data) : ^data;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Restartable bit-period counter: o_bit_tick is high in the last cycle of every bit period.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  output logic o_bit_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clear || (r_count == LAST)) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_bit_tick = (r_count == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int PARITY       = PARITY_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_ready,
  output logic       tx_done,
  output logic       tx
);

  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  uart_tx_state_t r_state;
  logic           r_tx_ready_last;
  logic [2:0]     r_bit_cnt;
  logic [7:0]     r_shift;
  logic           r_parity;
  logic           r_tx;
  logic           r_tx_done;
  logic           w_edge;
  logic           w_accept;
  logic           w_bit_tick;
  logic           w_shift_en;

  assign w_edge     = tx_ready && !r_tx_ready_last;
  assign w_accept   = w_edge && (r_state == UART_TX_IDLE);
  assign w_shift_en = w_bit_tick && ((r_state == UART_TX_START) || (r_state == UART_TX_DATA));

  // Bit period restarts on accept so the start bit is a full period long
  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clock     (clock),
    .reset     (reset),
    .i_clear   (w_accept),
    .o_bit_tick(w_bit_tick)
  );

  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_shift  <= tx_data;
      r_parity <= parity_bit(tx_data, PARITY);
    end else if (w_shift_en) begin
      r_shift <= {1'b0, r_shift[7:1]};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state         <= UART_TX_IDLE;
      r_tx_ready_last <= 1'b0;
      r_bit_cnt       <= 3'd0;
      r_tx            <= 1'b1;
      r_tx_done       <= 1'b1;
    end else begin
      r_tx_ready_last <= tx_ready;
      case (r_state)
        UART_TX_IDLE: begin
          r_tx      <= 1'b1;
          r_tx_done <= 1'b1;
          r_bit_cnt <= 3'd0;
          if (w_edge) begin
            r_tx      <= 1'b0;
            r_tx_done <= 1'b0;
            r_state   <= UART_TX_START;
          end
        end
        UART_TX_START: begin
          if (w_bit_tick) begin
            r_tx      <= r_shift[0];
            r_bit_cnt <= 3'd0;
            r_state   <= UART_TX_DATA;
          end
        end
        UART_TX_DATA: begin
          if (w_bit_tick) begin
            if (r_bit_cnt == 3'd7) begin
              r_bit_cnt <= 3'd0;
              if (PARITY != PARITY_NONE) begin
                r_tx    <= r_parity;
                r_state <= UART_TX_PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= UART_TX_STOP;
              end
            end else begin
              r_tx      <= r_shift[0];
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
        end
        UART_TX_PARITY: begin
          if (w_bit_tick) begin
            r_tx      <= 1'b1;
            r_bit_cnt <= 3'd0;
            r_state   <= UART_TX_STOP;
          end
        end
        UART_TX_STOP: begin
          if (w_bit_tick) begin
            if (r_bit_cnt == STOP_LAST) begin
              r_bit_cnt <= 3'd0;
              r_tx_done <= 1'b1;
              r_state   <= UART_TX_IDLE;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
        end
        default: begin
          r_tx      <= 1'b1;
          r_tx_done <= 1'b1;
          r_bit_cnt <= 3'd0;
          r_state   <= UART_TX_IDLE;
        end
      endcase
    end
  end

  assign tx      = r_tx;
  assign tx_done = r_tx_done;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four parity/stop configurations driven in lockstep and checked per cycle.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int C    = 4;
  localparam int NDUT = 4;
  localparam int FMAX = 48;
  localparam int PM [NDUT] = '{PARITY_NONE, PARITY_EVEN, PARITY_ODD, PARITY_EVEN};
  localparam int SB [NDUT] = '{1, 1, 1, 2};

  typedef struct {
    logic [7:0] data;
    logic       pe;       // expected even-parity bit
    bit         disturb;  // change data and re-edge tx_ready mid-frame
  } vec_t;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [7:0]      tx_data = 8'h00;
  logic            tx_ready = 1'b0;
  logic [NDUT-1:0] tx_w;
  logic [NDUT-1:0] done_w;

  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;
  int   rx_bad = 0;
  logic [7:0] rxq [$];

  always #5 clock = ~clock;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    uart_tx #(
      .CLKS_PER_BIT(C),
      .PARITY      (PM[g]),
      .STOP_BITS   (SB[g])
    ) u_dut (
      .clock   (clock),
      .reset   (reset),
      .tx_data (tx_data),
      .tx_ready(tx_ready),
      .tx_done (done_w[g]),
      .tx      (tx_w[g])
    );
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, k, act, exp);
    end
  endtask

  function automatic int frame_len(input int d);
    return C * (9 + ((PM[d] != PARITY_NONE) ? 1 : 0) + SB[d]);
  endfunction

  // Expected line level during bit period b of a frame
  function automatic logic exp_tx(input logic [7:0] data, input logic pe, input int d, input int b);
    logic pbit;
    pbit = (PM[d] == PARITY_ODD) ? ~pe : pe;
    if (b == 0) return 1'b0;
    if (b <= 8) return data[b-1];
    if ((PM[d] != PARITY_NONE) && (b == 9)) return pbit;
    return 1'b1;
  endfunction

  task automatic check_idle(input string nm, input int k);
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("%s_tx[%0d]", nm, d), k, 32'(tx_w[d]), 32'd1);
      chk($sformatf("%s_done[%0d]", nm, d), k, 32'(done_w[d]), 32'd1);
    end
  endtask

  // Called at a negedge after the edge-causing inputs are applied; ends at a negedge with tx_ready low
  task automatic run_frame(input logic [7:0] data, input logic pe, input bit disturb);
    for (int k = 1; k <= FMAX + 1; k++) begin
      @(posedge clock);
      @(negedge clock);
      for (int d = 0; d < NDUT; d++) begin
        chk($sformatf("tx[%0d]", d), k, 32'(tx_w[d]),
            32'((k <= frame_len(d)) ? exp_tx(data, pe, d, (k - 1) / C) : 1'b1));
        chk($sformatf("done[%0d]", d), k, 32'(done_w[d]), 32'((k > frame_len(d)) ? 1'b1 : 1'b0));
      end
      if (disturb && k == 10) tx_data = 8'hFF;
      if (disturb && k == 12) tx_ready = 1'b0;
      if (disturb && k == 13) tx_ready = 1'b1;
    end
    for (int k = 1; k <= 8; k++) begin
      @(posedge clock);
      @(negedge clock);
      check_idle("hold", FMAX + 1 + k);
    end
    tx_ready = 1'b0;
  endtask

  task automatic send(input logic [7:0] data, input logic pe, input bit disturb);
    @(negedge clock);
    tx_data  = data;
    tx_ready = 1'b1;
    run_frame(data, pe, disturb);
  endtask

  function automatic logic even_par(input logic [7:0] d);
    return ($countones(d) % 2) == 1;
  endfunction

  // Independent line receiver for configuration 0 (no parity, 1 stop bit)
  initial begin
    forever begin
      logic [7:0] b;
      @(negedge clock);
      if (mon_en && tx_w[0] == 1'b0) begin
        repeat (C / 2) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
          repeat (C) @(negedge clock);
          b[i] = tx_w[0];
        end
        repeat (C) @(negedge clock);
        if (tx_w[0]) rxq.push_back(b);
        else rx_bad++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs [8];
    logic [7:0] r;
    logic [7:0] hi [3];

    vecs[0] = '{8'h55, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 1'b0, 1'b0};
    vecs[2] = '{8'h07, 1'b1, 1'b0};
    vecs[3] = '{8'h41, 1'b0, 1'b0};
    vecs[4] = '{8'hA5, 1'b0, 1'b1};
    vecs[5] = '{8'h00, 1'b0, 1'b0};
    vecs[6] = '{8'hFF, 1'b0, 1'b0};
    vecs[7] = '{8'h80, 1'b1, 1'b0};

    @(negedge clock);
    check_idle("reset", 0);
    reset = 1'b1;
    @(negedge clock);
    check_idle("post_reset", 0);

    for (int i = 0; i < 8; i++) send(vecs[i].data, vecs[i].pe, vecs[i].disturb);

    for (int i = 0; i < 6; i++) begin
      r = 8'($urandom_range(0, 255));
      send(r, even_par(r), 1'b0);
    end

    hi[0] = 8'h48;
    hi[1] = 8'h69;
    hi[2] = 8'h00;
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (hi[i] == 8'h00) break;
      send(hi[i], even_par(hi[i]), 1'b0);
    end
    mon_en = 1'b0;
    chk("hi_frames", 0, 32'(rxq.size()), 32'd2);
    chk("hi_bad_stop", 0, 32'(rx_bad), 32'd0);
    if (rxq.size() >= 1) chk("hi_byte0", 0, 32'(rxq[0]), 32'h48);
    if (rxq.size() >= 2) chk("hi_byte1", 0, 32'(rxq[1]), 32'h69);

    @(negedge clock);
    tx_data  = 8'h3C;
    tx_ready = 1'b1;
    repeat (12) @(negedge clock);
    for (int d = 0; d < NDUT; d++) chk($sformatf("mid_tx[%0d]", d), 12, 32'(tx_w[d]), 32'((8'h3C >> 1) & 1));
    reset = 1'b0;
    #1;
    check_idle("async_reset", 12);
    tx_data = 8'hC3;
    @(negedge clock);
    check_idle("in_reset", 13);
    reset = 1'b1;
    run_frame(8'hC3, even_par(8'hC3), 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
